// File: rtl/i2c_transaction_sequencer.sv
// rtl/i2c_transaction_sequencer.sv - register-level request to i2c_master_controller command sequencer
// Emits START/WR/RESTART/RD/STOP through the ready/strobe handshake and reports one done pulse per request.
module i2c_transaction_sequencer #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic       i_rw,
    input  logic [6:0] i_dev_addr,
    input  logic [7:0] i_reg_addr,
    input  logic [7:0] i_wdata,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_nack,
    output logic       o_timeout,
    output logic [7:0] o_rdata,
    output logic [2:0] o_cmd,
    output logic [7:0] o_din,
    output logic       o_wr_i2c,
    input  logic       i_ready,
    input  logic       i_nack,
    input  logic [7:0] i_dout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    localparam logic [2:0] CMD_START   = 3'b001;
    localparam logic [2:0] CMD_WR      = 3'b010;
    localparam logic [2:0] CMD_RD      = 3'b011;
    localparam logic [2:0] CMD_STOP    = 3'b100;
    localparam logic [2:0] CMD_RESTART = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACC,
        S_WAIT_DONE,
        S_EVAL,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    step_q, step_d;
    logic          rw_q, rw_d;
    logic [6:0]    dev_q, dev_d;
    logic [7:0]    reg_q, reg_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          nack_q, nack_d;
    logic          timeout_q, timeout_d;
    logic [7:0]    rdata_q, rdata_d;
    logic [2:0]    cmd_q, cmd_d;
    logic [7:0]    din_q, din_d;
    logic          wr_q, wr_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tmo_hit;
    logic          waiting;
    logic [2:0]    stop_step;

    // Command/data for a given step; read sequences use the 7-step table, writes the 5-step one.
    function automatic logic [10:0] step_cmd(input logic [2:0] step, input logic rw,
                                             input logic [6:0] dev, input logic [7:0] ra,
                                             input logic [7:0] wd);
        logic [10:0] r;
        r = {CMD_STOP, 8'h00};
        if (!rw) begin
            case (step)
                3'd0:    r = {CMD_START, 8'h00};
                3'd1:    r = {CMD_WR, dev, 1'b0};
                3'd2:    r = {CMD_WR, ra};
                3'd3:    r = {CMD_WR, wd};
                default: r = {CMD_STOP, 8'h00};
            endcase
        end else begin
            case (step)
                3'd0:    r = {CMD_START, 8'h00};
                3'd1:    r = {CMD_WR, dev, 1'b0};
                3'd2:    r = {CMD_WR, ra};
                3'd3:    r = {CMD_RESTART, 8'h00};
                3'd4:    r = {CMD_WR, dev, 1'b1};
                3'd5:    r = {CMD_RD, 8'h01};
                default: r = {CMD_STOP, 8'h00};
            endcase
        end
        return r;
    endfunction

    assign tmo_hit   = (tcnt_q == TMAX);
    assign waiting   = (state_q == S_ISSUE) || (state_q == S_WAIT_ACC) || (state_q == S_WAIT_DONE);
    assign stop_step = rw_q ? 3'd6 : 3'd4;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            step_q    <= 3'd0;
            rw_q      <= 1'b0;
            dev_q     <= 7'h00;
            reg_q     <= 8'h00;
            wdata_q   <= 8'h00;
            nack_q    <= 1'b0;
            timeout_q <= 1'b0;
            rdata_q   <= 8'h00;
            cmd_q     <= 3'b000;
            din_q     <= 8'h00;
            wr_q      <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            tcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            rw_q      <= rw_d;
            dev_q     <= dev_d;
            reg_q     <= reg_d;
            wdata_q   <= wdata_d;
            nack_q    <= nack_d;
            timeout_q <= timeout_d;
            rdata_q   <= rdata_d;
            cmd_q     <= cmd_d;
            din_q     <= din_d;
            wr_q      <= wr_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            tcnt_q    <= tcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (i_start) state_d = S_ISSUE;
            S_ISSUE:     if (i_ready) state_d = S_WAIT_ACC;
                         else if (tmo_hit) state_d = S_DONE;
            S_WAIT_ACC:  if (!i_ready) state_d = S_WAIT_DONE;
                         else if (tmo_hit) state_d = S_DONE;
            S_WAIT_DONE: if (i_ready) state_d = S_EVAL;
                         else if (tmo_hit) state_d = S_DONE;
            S_EVAL:      state_d = (cmd_q == CMD_STOP) ? S_DONE : S_ISSUE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        step_d    = step_q;
        rw_d      = rw_q;
        dev_d     = dev_q;
        reg_d     = reg_q;
        wdata_d   = wdata_q;
        nack_d    = nack_q;
        timeout_d = timeout_q;
        rdata_d   = rdata_q;
        cmd_d     = cmd_q;
        din_d     = din_q;
        wr_d      = 1'b0;
        done_d    = (state_d == S_DONE);
        busy_d    = (state_d != S_IDLE);
        tcnt_d    = (state_d != state_q || !waiting) ? '0 : tcnt_q + 1'b1;

        if (state_q == S_IDLE && i_start) begin
            step_d    = 3'd0;
            rw_d      = i_rw;
            dev_d     = i_dev_addr;
            reg_d     = i_reg_addr;
            wdata_d   = i_wdata;
            nack_d    = 1'b0;
            timeout_d = 1'b0;
        end
        if (state_q == S_ISSUE && i_ready) wr_d = 1'b1;
        // Only a handshake wait can jump straight to DONE; that path is the hung-controller abort.
        if (waiting && state_d == S_DONE) timeout_d = 1'b1;
        if (state_q == S_EVAL) begin
            if (cmd_q == CMD_WR && i_nack) begin
                nack_d = 1'b1;
                step_d = stop_step;
            end else begin
                if (cmd_q == CMD_RD) rdata_d = i_dout;
                if (cmd_q != CMD_STOP) step_d = step_q + 3'd1;
            end
        end
        if (state_d == S_ISSUE && state_q != S_ISSUE)
            {cmd_d, din_d} = step_cmd(step_d, rw_d, dev_d, reg_d, wdata_d);
    end

    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_nack    = nack_q;
    assign o_timeout = timeout_q;
    assign o_rdata   = rdata_q;
    assign o_cmd     = cmd_q;
    assign o_din     = din_q;
    assign o_wr_i2c  = wr_q;

endmodule

// File: tb/tb_i2c_transaction_sequencer.sv
// tb/tb_i2c_transaction_sequencer.sv - directed bench for i2c_transaction_sequencer
// A small controller model answers each strobe after a fixed delay and logs the commands.
module tb_i2c_transaction_sequencer;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_start;
    logic       i_rw;
    logic [6:0] i_dev_addr;
    logic [7:0] i_reg_addr;
    logic [7:0] i_wdata;
    logic       o_busy, o_done, o_nack, o_timeout, o_wr_i2c;
    logic [7:0] o_rdata, o_din;
    logic [2:0] o_cmd;
    logic       i_ready, i_nack;
    logic [7:0] i_dout;

    int checks = 0;
    int errors = 0;

    logic [2:0] log_cmd [0:31];
    logic [7:0] log_din [0:31];
    int         n_log = 0;
    int         nack_idx = -1;
    logic [7:0] rd_val = 8'h00;
    logic       hang = 1'b0;
    int         done_cnt = 0;
    logic       prev_wr = 1'b0;

    logic       got_done, got_nack, got_tmo;
    logic [7:0] got_rdata;

    i2c_transaction_sequencer #(.TIMEOUT_CYCLES(20)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_rw(i_rw),
        .i_dev_addr(i_dev_addr), .i_reg_addr(i_reg_addr), .i_wdata(i_wdata),
        .o_busy(o_busy), .o_done(o_done), .o_nack(o_nack), .o_timeout(o_timeout),
        .o_rdata(o_rdata), .o_cmd(o_cmd), .o_din(o_din), .o_wr_i2c(o_wr_i2c),
        .i_ready(i_ready), .i_nack(i_nack), .i_dout(i_dout)
    );

    always #5 i_clk = ~i_clk;

    // Controller model: drop ready after a strobe, return it 3 cycles later unless hung.
    initial begin
        int idx;
        i_ready = 1'b1;
        i_nack  = 1'b0;
        i_dout  = 8'h00;
        forever begin
            @(posedge i_clk); #1;
            if (o_wr_i2c) begin
                checks++;
                if (!i_ready) begin
                    errors++;
                    $display("FAIL wr_while_not_ready got wr=1 ready=%b required ready=1", i_ready);
                end
                idx = n_log;
                if (idx < 32) begin
                    log_cmd[idx] = o_cmd;
                    log_din[idx] = o_din;
                end
                n_log++;
                i_ready = 1'b0;
                if (!hang) begin
                    repeat (3) @(posedge i_clk);
                    #1;
                    i_nack  = (idx == nack_idx);
                    i_dout  = rd_val;
                    i_ready = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge i_clk); #1;
            if (o_wr_i2c) begin
                checks++;
                if (prev_wr) begin
                    errors++;
                    $display("FAIL wr_consecutive got two strobes in a row required one");
                end
            end
            prev_wr = o_wr_i2c;
            if (o_done) done_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic start_req(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                             input logic [7:0] wd);
        @(negedge i_clk);
        i_start = 1'b1; i_rw = rw; i_dev_addr = dev; i_reg_addr = ra; i_wdata = wd;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done();
        got_done = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge i_clk);
            if (o_done) begin
                got_done  = 1'b1;
                got_nack  = o_nack;
                got_tmo   = o_timeout;
                got_rdata = o_rdata;
                break;
            end
        end
        checks++;
        if (!got_done) begin
            errors++;
            $display("FAIL done_wait got no o_done within 300 cycles required o_done=1");
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_start = 1'b0; i_rw = 1'b0;
        i_dev_addr = 7'h00; i_reg_addr = 8'h00; i_wdata = 8'h00;
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b required 0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b required 0", o_done); end
        checks++; if (o_nack !== 1'b0 || o_timeout !== 1'b0) begin errors++; $display("FAIL rst_flags got %b%b required 00", o_nack, o_timeout); end
        checks++; if (o_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got %h required 00", o_rdata); end
        checks++; if (o_cmd !== 3'b000 || o_din !== 8'h00) begin errors++; $display("FAIL rst_cmd got %b/%h required 000/00", o_cmd, o_din); end
        checks++; if (o_wr_i2c !== 1'b0) begin errors++; $display("FAIL rst_wr got %b required 0", o_wr_i2c); end
    endtask

    task automatic test_write();
        logic [2:0] ec [5];
        logic [7:0] ed [5];
        int d0;
        ec = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b100};
        ed = '{8'h00, 8'hA0, 8'h10, 8'hA5, 8'h00};
        n_log = 0; d0 = done_cnt;
        start_req(1'b0, 7'h50, 8'h10, 8'hA5);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL write_busy got %b required 1", o_busy); end
        wait_done();
        checks++; if (n_log != 5) begin errors++; $display("FAIL write_count got %0d required 5", n_log); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (log_cmd[i] !== ec[i] || log_din[i] !== ed[i]) begin
                errors++;
                $display("FAIL write_cmd%0d got %b/%h required %b/%h", i, log_cmd[i], log_din[i], ec[i], ed[i]);
            end
        end
        checks++; if (got_nack !== 1'b0 || got_tmo !== 1'b0) begin errors++; $display("FAIL write_flags got %b%b required 00", got_nack, got_tmo); end
        @(negedge i_clk);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL write_busy_fall got %b required 0", o_busy); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL write_done_count got %0d required 1", done_cnt - d0); end
    endtask

    task automatic test_read();
        logic [2:0] ec [7];
        logic [7:0] ed [7];
        ec = '{3'b001, 3'b010, 3'b010, 3'b101, 3'b010, 3'b011, 3'b100};
        ed = '{8'h00, 8'hA0, 8'h22, 8'h00, 8'hA1, 8'h01, 8'h00};
        n_log = 0; rd_val = 8'h5A;
        start_req(1'b1, 7'h50, 8'h22, 8'hFF);
        wait_done();
        checks++; if (n_log != 7) begin errors++; $display("FAIL read_count got %0d required 7", n_log); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (log_cmd[i] !== ec[i] || log_din[i] !== ed[i]) begin
                errors++;
                $display("FAIL read_cmd%0d got %b/%h required %b/%h", i, log_cmd[i], log_din[i], ec[i], ed[i]);
            end
        end
        checks++; if (got_rdata !== 8'h5A) begin errors++; $display("FAIL read_rdata got %h required 5A", got_rdata); end
        checks++; if (got_nack !== 1'b0) begin errors++; $display("FAIL read_nack got %b required 0", got_nack); end
    endtask

    task automatic test_nack();
        n_log = 0; nack_idx = 1; rd_val = 8'hC3;
        start_req(1'b0, 7'h50, 8'h10, 8'hA5);
        wait_done();
        nack_idx = -1;
        checks++; if (n_log != 3) begin errors++; $display("FAIL nack_count got %0d required 3", n_log); end
        checks++; if (log_cmd[2] !== 3'b100 || log_din[2] !== 8'h00) begin errors++; $display("FAIL nack_stop got %b/%h required 100/00", log_cmd[2], log_din[2]); end
        checks++; if (got_nack !== 1'b1) begin errors++; $display("FAIL nack_flag got %b required 1", got_nack); end
        checks++; if (got_rdata !== 8'h5A) begin errors++; $display("FAIL nack_rdata got %h required 5A", got_rdata); end
    endtask

    task automatic test_timeout();
        n_log = 0; hang = 1'b1;
        start_req(1'b0, 7'h50, 8'h10, 8'hA5);
        wait_done();
        checks++; if (got_tmo !== 1'b1) begin errors++; $display("FAIL tmo_flag got %b required 1", got_tmo); end
        checks++; if (got_nack !== 1'b0) begin errors++; $display("FAIL tmo_nack got %b required 0", got_nack); end
        repeat (5) @(negedge i_clk);
        checks++; if (n_log != 1) begin errors++; $display("FAIL tmo_strobes got %0d required 1", n_log); end
        hang = 1'b0;
        i_ready = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_back_to_back();
        int d0;
        n_log = 0; d0 = done_cnt;
        start_req(1'b0, 7'h50, 8'h01, 8'h11);
        repeat (4) @(negedge i_clk);
        i_start = 1'b1; i_rw = 1'b1; i_dev_addr = 7'h11; i_reg_addr = 8'h77;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_done();
        i_start = 1'b1; i_rw = 1'b1; i_dev_addr = 7'h11; i_reg_addr = 8'h77;
        @(negedge i_clk);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL b2b_gap got busy=%b required 0", o_busy); end
        i_rw = 1'b0; i_dev_addr = 7'h33; i_reg_addr = 8'h44; i_wdata = 8'h55;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_done();
        checks++; if (n_log != 10) begin errors++; $display("FAIL b2b_count got %0d required 10", n_log); end
        checks++; if (log_din[3] !== 8'h11 || log_din[6] !== 8'h66 || log_din[7] !== 8'h44 || log_din[8] !== 8'h55)
            begin errors++; $display("FAIL b2b_data got %h %h %h %h required 11 66 44 55", log_din[3], log_din[6], log_din[7], log_din[8]); end
        @(negedge i_clk);
        checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_done_count got %0d required 2", done_cnt - d0); end
    endtask

    task automatic test_reset_mid();
        n_log = 0; rd_val = 8'h5A;
        start_req(1'b1, 7'h50, 8'h22, 8'h00);
        for (int k = 0; k < 200 && n_log < 3; k++) @(negedge i_clk);
        checks++; if (n_log != 3) begin errors++; $display("FAIL rmid_reach got %0d strobes required 3", n_log); end
        @(posedge i_clk); #2;
        i_reset = 1'b1;
        #1;
        checks++; if (o_busy !== 1'b0 || o_wr_i2c !== 1'b0 || o_done !== 1'b0) begin errors++; $display("FAIL rmid_ctrl got busy=%b wr=%b done=%b required 000", o_busy, o_wr_i2c, o_done); end
        checks++; if (o_cmd !== 3'b000 || o_din !== 8'h00) begin errors++; $display("FAIL rmid_cmd got %b/%h required 000/00", o_cmd, o_din); end
        checks++; if (o_rdata !== 8'h00 || o_nack !== 1'b0 || o_timeout !== 1'b0) begin errors++; $display("FAIL rmid_data got %h %b%b required 00 00", o_rdata, o_nack, o_timeout); end
        @(negedge i_clk);
        i_reset = 1'b0;
        for (int k = 0; k < 20 && !i_ready; k++) @(negedge i_clk);
        n_log = 0;
        start_req(1'b0, 7'h50, 8'h10, 8'hA5);
        wait_done();
        checks++; if (n_log != 5 || log_cmd[4] !== 3'b100 || log_din[3] !== 8'hA5) begin errors++; $display("FAIL rmid_after got n=%0d last=%b data=%h required 5 100 A5", n_log, log_cmd[4], log_din[3]); end
        checks++; if (got_nack !== 1'b0 || got_tmo !== 1'b0) begin errors++; $display("FAIL rmid_flags got %b%b required 00", got_nack, got_tmo); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_nack();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge i_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
